hog_block_sequencer: RTL and testbench

//   Sequences cell histograms from cell_histogram into overlapping 2x2-cell HOG blocks for block normalisation.

---
 rtl/hog_block_sequencer_if.sv | 33 +++
 rtl/hog_block_sequencer.sv | 105 ++++++++++
 tb/tb_hog_block_sequencer.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hog_block_sequencer_if.sv
// rtl/hog_block_sequencer_if.sv - cell input and block output handshake bundle
interface hog_block_sequencer_if #(
  parameter int OUTPUT_BIN_WIDTH = 14,
  parameter int HISTOGRAM_WIDTH  = OUTPUT_BIN_WIDTH * 9,
  parameter int IMAGE_WIDTH      = 32,
  parameter int IMAGE_HEIGHT     = 32,
  parameter int CELL_SIZE        = 8
);
  localparam int COL_W = $clog2(IMAGE_WIDTH / CELL_SIZE);
  localparam int ROW_W = $clog2(IMAGE_HEIGHT / CELL_SIZE);

  logic                         in_valid;
  logic                         in_ready;
  logic [HISTOGRAM_WIDTH-1:0]   cell_histogram;
  logic                         out_valid;
  logic                         out_ready;
  logic [4*HISTOGRAM_WIDTH-1:0] block_histogram;
  logic [COL_W-1:0]             block_col;
  logic [ROW_W-1:0]             block_row;
  logic                         out_last;

  // cell source / block sink side
  modport master (
    output in_valid, cell_histogram, out_ready,
    input  in_ready, out_valid, block_histogram, block_col, block_row, out_last
  );

  // sequencer side
  modport slave (
    input  in_valid, cell_histogram, out_ready,
    output in_ready, out_valid, block_histogram, block_col, block_row, out_last
  );
endinterface

// File: rtl/hog_block_sequencer.sv
// rtl/hog_block_sequencer.sv - raster cell histograms to overlapping 2x2 HOG blocks
module hog_block_sequencer #(
  parameter int OUTPUT_BIN_WIDTH = 14,
  parameter int HISTOGRAM_WIDTH  = 126,
  parameter int IMAGE_WIDTH      = 32,
  parameter int IMAGE_HEIGHT     = 32,
  parameter int CELL_SIZE        = 8
) (
  input logic                  clk,
  input logic                  rst,
  hog_block_sequencer_if.slave bus
);
  localparam int CPR   = IMAGE_WIDTH / CELL_SIZE;
  localparam int CROWS = IMAGE_HEIGHT / CELL_SIZE;
  localparam int COL_W = $clog2(CPR);
  localparam int ROW_W = $clog2(CROWS);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(CPR - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(CROWS - 1);

  localparam logic [1:0] S_FIRST_ROW = 2'd0;
  localparam logic [1:0] S_ROW_START = 2'd1;
  localparam logic [1:0] S_EMIT      = 2'd2;

  // a cell histogram is nine bins packed back to back
  if (HISTOGRAM_WIDTH != 9 * OUTPUT_BIN_WIDTH) begin : g_width_check
    $error("HISTOGRAM_WIDTH must equal 9*OUTPUT_BIN_WIDTH");
  end

  logic [COL_W-1:0]             col;
  logic [ROW_W-1:0]             row;
  logic [1:0]                   state;
  logic [HISTOGRAM_WIDTH-1:0]   lb [CPR];
  logic [HISTOGRAM_WIDTH-1:0]   tl;
  logic [HISTOGRAM_WIDTH-1:0]   bl;
  logic [4*HISTOGRAM_WIDTH-1:0] blk;
  logic [COL_W-1:0]             blk_col;
  logic [ROW_W-1:0]             blk_row;
  logic                         valid_q;
  logic                         last_q;
  logic                         ready;
  logic                         acc;
  logic                         emit;

  // single output stage: a new cell may enter whenever that stage can drain
  assign ready = ~valid_q | bus.out_ready;
  assign acc   = bus.in_valid & ready;
  assign emit  = acc & (state == S_EMIT);

  assign bus.in_ready        = ready;
  assign bus.out_valid       = valid_q;
  assign bus.out_last        = last_q;
  assign bus.block_histogram = blk;
  assign bus.block_col       = blk_col;
  assign bus.block_row       = blk_row;

  // raster position of the next cell and row-phase FSM, advanced only on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col   <= '0;
      row   <= '0;
      state <= S_FIRST_ROW;
    end else if (acc) begin
      if (col == LAST_COL) begin
        col <= '0;
        row <= (row == LAST_ROW) ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
      case (state)
        S_FIRST_ROW: if (col == LAST_COL) state <= S_ROW_START;
        S_ROW_START: state <= S_EMIT;
        S_EMIT:      if (col == LAST_COL) state <= (row == LAST_ROW) ? S_FIRST_ROW : S_ROW_START;
        default:     state <= S_FIRST_ROW;
      endcase
    end
  end

  // line buffer plus left-column registers; the first row of a frame overwrites them
  always_ff @(posedge clk) begin
    if (acc) begin
      tl      <= lb[col];
      bl      <= bus.cell_histogram;
      lb[col] <= bus.cell_histogram;
    end
  end

  // output stage: a new block replaces the current one, else a handshake drains it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      blk     <= '0;
      blk_col <= '0;
      blk_row <= '0;
    end else if (emit) begin
      valid_q <= 1'b1;
      blk     <= {bus.cell_histogram, bl, lb[col], tl};
      blk_col <= col - COL_W'(1);
      blk_row <= row - ROW_W'(1);
      last_q  <= (row == LAST_ROW) && (col == LAST_COL);
    end else if (valid_q && bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_hog_block_sequencer.sv
// tb/tb_hog_block_sequencer.sv - randomized scoreboard bench for hog_block_sequencer
module tb_hog_block_sequencer;
  localparam int OBW   = 14;
  localparam int HW    = 126;
  localparam int BW    = 4 * HW;
  localparam int CPR   = 4;
  localparam int CROWS = 4;
  localparam int NCELL = CPR * CROWS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hog_block_sequencer_if #(
    .OUTPUT_BIN_WIDTH(OBW), .HISTOGRAM_WIDTH(HW),
    .IMAGE_WIDTH(32), .IMAGE_HEIGHT(32), .CELL_SIZE(8)
  ) bus ();

  hog_block_sequencer #(
    .OUTPUT_BIN_WIDTH(OBW), .HISTOGRAM_WIDTH(HW),
    .IMAGE_WIDTH(32), .IMAGE_HEIGHT(32), .CELL_SIZE(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int ready_mode = 0;

  logic [BW-1:0] obs_blk [$];
  int            obs_col [$];
  int            obs_row [$];
  bit            obs_last[$];

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [HW-1:0] mk_cell(input int n);
    logic [HW-1:0] h = '0;
    for (int k = 0; k < 9; k++) h[k*OBW +: OBW] = OBW'(16 * n + k);
    return h;
  endfunction

  function automatic logic [BW-1:0] mk_block(input int tl, input int tr, input int bl, input int br);
    return {mk_cell(br), mk_cell(bl), mk_cell(tr), mk_cell(tl)};
  endfunction

  function automatic logic [HW-1:0] rnd_cell();
    logic [127:0] t = {$urandom, $urandom, $urandom, $urandom};
    return t[HW-1:0];
  endfunction

  // reference model: frame grid indexed by raster position, one output register
  logic [HW-1:0] grid [CROWS][CPR];
  int            m_idx;
  bit            m_valid;
  logic [BW-1:0] m_block;
  int            m_col, m_row;
  bit            m_last;
  logic          m_acc;
  assign m_acc = bus.in_valid && (!m_valid || bus.out_ready);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_idx <= 0; m_valid <= 0; m_block <= '0; m_col <= 0; m_row <= 0; m_last <= 0;
    end else if (m_acc) begin
      grid[m_idx / CPR][m_idx % CPR] <= bus.cell_histogram;
      m_idx <= (m_idx + 1) % NCELL;
      if (m_idx / CPR >= 1 && m_idx % CPR >= 1) begin
        m_valid <= 1;
        m_block <= {bus.cell_histogram, grid[m_idx / CPR][m_idx % CPR - 1],
                    grid[m_idx / CPR - 1][m_idx % CPR], grid[m_idx / CPR - 1][m_idx % CPR - 1]};
        m_col   <= m_idx % CPR - 1;
        m_row   <= m_idx / CPR - 1;
        m_last  <= (m_idx == NCELL - 1);
      end else if (m_valid && bus.out_ready) begin
        m_valid <= 0;
      end
    end else if (m_valid && bus.out_ready) begin
      m_valid <= 0;
    end
  end

  // compare DUT with model every cycle, log handshaken blocks
  always @(negedge clk) begin
    if (!rst) begin
      check("in_ready", bus.in_ready, !m_valid || bus.out_ready);
      check("out_valid", bus.out_valid, m_valid);
      if (m_valid) begin
        check("block_histogram", bus.block_histogram, m_block);
        check("block_col", bus.block_col, m_col);
        check("block_row", bus.block_row, m_row);
        check("out_last", bus.out_last, m_last);
      end
      if (bus.out_valid && bus.out_ready) begin
        obs_blk.push_back(bus.block_histogram);
        obs_col.push_back(int'(bus.block_col));
        obs_row.push_back(int'(bus.block_row));
        obs_last.push_back(bus.out_last);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (ready_mode == 2) bus.out_ready = 1'($urandom_range(0, 1));
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic try_cell(input logic [HW-1:0] h, input int budget, output bit ok);
    bit rdy;
    ok = 0;
    bus.in_valid = 1'b1;
    bus.cell_histogram = h;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      if (rdy) begin ok = 1; break; end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic send(input logic [HW-1:0] h);
    bit ok;
    try_cell(h, 200, ok);
    if (!ok) begin n_checks++; n_fail++; $display("FAIL accept_timeout: got 0 expected 1"); end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    idle(2);
    @(posedge clk); #5;
    rst = 1'b0;
    idle(1);
    obs_blk.delete(); obs_col.delete(); obs_row.delete(); obs_last.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] emit_mask = 16'hEEE0;
    logic [BW-1:0] ones_lane3 = {{HW{1'b1}}, {(3*HW){1'b0}}};
    logic [BW-1:0] blk0;
    time t0;
    bit ok;
    int n0;

    bus.in_valid = 1'b0;
    bus.cell_histogram = '0;
    bus.out_ready = 1'b1;

    // 1: reset state, continuous frame
    do_reset();
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_out_last", bus.out_last, 0);
    check("reset_block", bus.block_histogram, 0);
    check("reset_col", bus.block_col, 0);
    check("reset_row", bus.block_row, 0);
    t0 = $time;
    for (int n = 0; n < NCELL; n++) begin
      send(mk_cell(n));
      check($sformatf("valid_after_cell%0d", n), bus.out_valid, emit_mask[n]);
      if (n == 5) begin
        blk0 = bus.block_histogram;
        check("first_lane0_bin0", blk0[0 +: OBW], 0);
        check("first_lane1_bin0", blk0[HW +: OBW], 16);
        check("first_lane2_bin0", blk0[2*HW +: OBW], 64);
        check("first_lane3_bin8", blk0[3*HW + 8*OBW +: OBW], 88);
      end
    end
    check("throughput_ns", $time - t0, 160);
    idle(2);
    check("frame1_blocks", obs_blk.size(), 9);
    check("frame1_first", obs_blk[0], mk_block(0, 1, 4, 5));
    // 4: frame end and restart
    check("last_block", obs_blk[8], mk_block(10, 11, 14, 15));
    check("last_col", obs_col[8], 2);
    check("last_row", obs_row[8], 2);
    check("last_flag", obs_last[8], 1);
    check("not_last_flag", obs_last[7], 0);
    for (int n = 0; n < 5; n++) begin
      send(mk_cell(n));
      check("restart_no_valid", bus.out_valid, 0);
    end
    check("restart_no_blocks", obs_blk.size(), 9);
    send(mk_cell(5));
    check("restart_sixth_valid", bus.out_valid, 1);

    // 2: backpressure hold
    do_reset();
    for (int n = 0; n < 5; n++) send(mk_cell(n));
    ready_mode = 1; bus.out_ready = 1'b0;
    send(mk_cell(5));
    try_cell(mk_cell(6), 10, ok);
    check("cell6_blocked", ok, 0);
    check("hold_block", bus.block_histogram, mk_block(0, 1, 4, 5));
    check("hold_in_ready", bus.in_ready, 0);
    ready_mode = 0; bus.out_ready = 1'b1;
    send(mk_cell(6));
    idle(2);
    check("hold_count", obs_blk.size(), 2);
    check("hold_first", obs_blk[0], mk_block(0, 1, 4, 5));
    check("hold_second", obs_blk[1], mk_block(1, 2, 5, 6));
    for (int n = 7; n < NCELL; n++) send(mk_cell(n));
    idle(2);
    check("hold_frame_blocks", obs_blk.size(), 9);

    // 3: random bubbles and backpressure over two frames
    do_reset();
    ready_mode = 2;
    for (int n = 0; n < 2 * NCELL; n++) begin
      send(rnd_cell());
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    ready_mode = 0; bus.out_ready = 1'b1;
    idle(3);
    check("random_blocks", obs_blk.size(), 18);
    n0 = 0;
    foreach (obs_last[i]) n0 += obs_last[i];
    check("random_last_count", n0, 2);

    // 5: reset with a block pending
    do_reset();
    for (int n = 0; n < 10; n++) send(mk_cell(n));
    check("pending_before_rst", bus.out_valid, 1);
    rst = 1'b1;
    #1;
    check("rst_async_valid", bus.out_valid, 0);
    check("rst_async_block", bus.block_histogram, 0);
    @(posedge clk); #5;
    rst = 1'b0;
    idle(1);
    obs_blk.delete(); obs_col.delete(); obs_row.delete(); obs_last.delete();
    for (int n = 0; n < NCELL; n++) send(mk_cell(n + 100));
    idle(2);
    check("post_rst_blocks", obs_blk.size(), 9);
    check("post_rst_first", obs_blk[0], mk_block(100, 101, 104, 105));

    // 6: only the bottom-right lane of the last block carries cell 15
    do_reset();
    for (int n = 0; n < NCELL; n++) send((n == NCELL - 1) ? {HW{1'b1}} : '0);
    idle(2);
    check("ones_blocks", obs_blk.size(), 9);
    check("ones_last_block", obs_blk[8], ones_lane3);
    check("ones_prev_block", obs_blk[7], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
